// File: rtl/uart_rx_buffer_pkg.sv
// Shared types for the UART receive path: data width, receiver FSM states, parity helper.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Even-parity bit: the value that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Firmware-side bundle of the UART receiver: serial input, FIFO read port, status and sticky errors.
interface uart_rx_buffer_if #(
    parameter int unsigned FIFO_DEPTH = 8
) ();
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                       rx_i;
    logic                       rd_en_i;
    logic                       clr_err_i;
    logic [uart_pkg::DATA_W-1:0] rd_data_o;
    logic                       rx_valid_o;
    logic                       fifo_full_o;
    logic [LVL_W-1:0]           level_o;
    logic                       frame_err_o;
    logic                       overrun_o;
    logic                       parity_err_o;

    modport slave (
        input  rx_i, rd_en_i, clr_err_i,
        output rd_data_o, rx_valid_o, fifo_full_o, level_o,
               frame_err_o, overrun_o, parity_err_o
    );

    modport master (
        output rx_i, rd_en_i, clr_err_i,
        input  rd_data_o, rx_valid_o, fifo_full_o, level_o,
               frame_err_o, overrun_o, parity_err_o
    );
endinterface

// File: rtl/uart_rx_buffer_fifo.sv
// Synchronous first-word-fall-through byte FIFO; occupancy tracked by a level counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [DATA_W-1:0]              data_i,
    output logic [DATA_W-1:0]              data_o,
    output logic [$clog2(DEPTH):0]         level_o,
    output logic                           full_o,
    output logic                           empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              pop_ok, push_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
    assign level_o = level_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
        else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/uart_rx_buffer.sv
// UART 8N1 receiver feeding a byte FIFO, with sticky framing/overrun/parity flags.
// Define RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    uart_rx_buffer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              push, frame_set;
    logic              fifo_full, fifo_empty;
`ifdef RX_PARITY_EN
    logic              parity_err_q, parity_err_d;
    logic              par_set;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef RX_PARITY_EN
        par_set   = 1'b0;
`endif
        if (state_q != RX_IDLE && cnt_q != '0) cnt_d = cnt_q - 1'b1;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = RX_START;
                    cnt_d   = CNT_HALF;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    state_d = rx_s_q ? RX_IDLE : RX_DATA;
                    cnt_d   = CNT_FULL;
                    bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    cnt_d   = CNT_FULL;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == '0) begin
                    par_set = (rx_s_q != even_parity(shift_q));
                    cnt_d   = CNT_FULL;
                    state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == '0) begin
                    push      = rx_s_q;
                    frame_set = !rx_s_q;
                    state_d   = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // A new error in the clear cycle keeps the flag set.
        frame_err_d = frame_set | (frame_err_q & ~bus.clr_err_i);
        overrun_d   = (push & fifo_full & ~bus.rd_en_i) | (overrun_q & ~bus.clr_err_i);
`ifdef RX_PARITY_EN
        parity_err_d = par_set | (parity_err_q & ~bus.clr_err_i);
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= bus.rx_i;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) parity_err_q <= 1'b0;
        else          parity_err_q <= parity_err_d;
    end
    assign bus.parity_err_o = parity_err_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    assign bus.frame_err_o = frame_err_q;
    assign bus.overrun_o   = overrun_q;
    assign bus.fifo_full_o = fifo_full;
    assign bus.rx_valid_o  = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push),
        .pop_i   (bus.rd_en_i),
        .data_i  (shift_q),
        .data_o  (bus.rd_data_o),
        .level_o (bus.level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: serial frames in, expected bytes queued, monitor checks pops.
module tb_uart_rx_buffer;
    import uart_pkg::*;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 8;
`ifdef RX_PARITY_EN
    localparam int unsigned NPAR  = 1;
`else
    localparam int unsigned NPAR  = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_buffer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_buffer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_q[$];
    bit          exp_ovr, exp_frm, exp_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted read must deliver the oldest byte the model holds.
    always @(negedge clk) begin
        if (!rst && bus.rd_en_i) begin
            if (exp_q.size() == 0) begin
                chk("rx_valid_on_read", {31'b0, bus.rx_valid_o}, 32'd0);
            end else begin
                chk("rx_valid_on_read", {31'b0, bus.rx_valid_o}, 32'd1);
                chk("rd_data", {24'b0, bus.rd_data_o}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_status(input string tag);
        logic [7:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        chk({tag, ".level"},   32'(bus.level_o), exp_q.size());
        chk({tag, ".valid"},   {31'b0, bus.rx_valid_o},  {31'b0, exp_q.size() != 0});
        chk({tag, ".full"},    {31'b0, bus.fifo_full_o}, {31'b0, exp_q.size() == DEPTH});
        chk({tag, ".head"},    {24'b0, bus.rd_data_o},   {24'b0, head});
        chk({tag, ".frame"},   {31'b0, bus.frame_err_o}, {31'b0, exp_frm});
        chk({tag, ".overrun"}, {31'b0, bus.overrun_o},   {31'b0, exp_ovr});
        chk({tag, ".parity"},  {31'b0, bus.parity_err_o},{31'b0, exp_par});
    endtask

    // Frame timing: edge seen 3 cycles after the line falls, start sampled CPB/2 later,
    // every following bit CPB apart; pop_at_stop raises rd_en_i exactly on the stop-sample edge.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit bad_par,
                              input bit pop_at_stop, input int abort_n);
        int   total;
        int   stop_n;
        int   j;
        logic v;
        total  = int'(CPB * (10 + NPAR));
        stop_n = int'(CPB / 2 + 3 + CPB * (9 + NPAR));
        @(posedge clk); #1;
        for (int n = 0; n < total; n++) begin
            if (n == abort_n) return;
            j = n / int'(CPB);
            if (j == 0)                         v = 1'b0;
            else if (j <= 8)                    v = d[j-1];
            else if (NPAR == 1 && j == 9)       v = (^d) ^ bad_par;
            else                                v = stop_bit;
            bus.rx_i    = v;
            bus.rd_en_i = pop_at_stop && (n == stop_n - 1);
            @(posedge clk); #1;
        end
        bus.rx_i    = 1'b1;
        bus.rd_en_i = 1'b0;
        if (stop_bit) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else                      exp_ovr = 1'b1;
        end else begin
            exp_frm = 1'b1;
        end
        if (NPAR == 1 && bad_par) exp_par = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic read_n(input int k);
        for (int i = 0; i < k; i++) begin
            bus.rd_en_i = 1'b1;
            @(posedge clk); #1;
            bus.rd_en_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_err();
        bus.clr_err_i = 1'b1;
        @(posedge clk); #1;
        bus.clr_err_i = 1'b0;
        exp_ovr = 1'b0;
        exp_frm = 1'b0;
        exp_par = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.rx_i      = 1'b1;
        bus.rd_en_i   = 1'b0;
        bus.clr_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_frm = 1'b0;
        exp_par = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_status("reset");

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        check_status("a5_rx");
        read_n(1);
        check_status("a5_read");

        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, -1);
            if (i >= 8) check_status("fill");
        end
        read_n(8);
        check_status("drain");
        clear_err();

        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h0A, 1'b1, 1'b0, 1'b1, -1);
        check_status("full_pushpop");
        read_n(8);
        check_status("full_pushpop_drain");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        check_status("frame_err");
        clear_err();
        check_status("frame_clr");

        bus.rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rx_i = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_status("glitch");
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
        check_status("after_glitch");

        send_frame(8'h77, 1'b1, 1'b0, 1'b0, int'(CPB * 4 + 6));
        do_reset();
        check_status("mid_reset");
        send_frame(8'h42, 1'b1, 1'b0, 1'b0, -1);
        check_status("after_reset");
        read_n(1);

`ifdef RX_PARITY_EN
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, -1);
        check_status("parity");
        read_n(1);
        clear_err();
`endif

        for (int it = 0; it < 24; it++) begin
            send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) == 0, -1);
            check_status("rand");
            read_n(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) clear_err();
        end
        read_n(DEPTH);
        check_status("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
